// File: rtl/conv_ofmap_tx.sv
// Streams a captured conv-stage output map as raster-ordered valid/ready beats.
// The frame is snapshotted on the conv_done rising edge, so upstream may reuse its map during the transfer.
module conv_ofmap_tx #(
    parameter int DATA_WIDTH      = 8,
    parameter int CONV_OFMAP_SIZE = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  conv_done,
    input  logic [DATA_WIDTH-1:0] conv_ofmap [0:CONV_OFMAP_SIZE-1][0:CONV_OFMAP_SIZE-1],
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy,
    output logic                  tx_done,
    output logic                  overrun
);
    // state      | meaning
    // TX_IDLE    | waiting for a conv_done rising edge
    // TX_CAPTURE | one cycle; snapshot conv_ofmap into pix_buf
    // TX_SEND    | streaming pix_buf[row][col] in raster order
    // TX_DONE    | one-cycle tx_done pulse, then back to idle
    localparam int N  = CONV_OFMAP_SIZE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

    typedef enum logic [1:0] {
        TX_IDLE    = 2'd0,
        TX_CAPTURE = 2'd1,
        TX_SEND    = 2'd2,
        TX_DONE    = 2'd3
    } tx_state_t;

    tx_state_t             state_q;
    logic                  conv_done_q;
    logic [CW-1:0]         row_q;
    logic [CW-1:0]         col_q;
    logic                  overrun_q;
    logic                  start;
    logic                  at_last;
    logic [DATA_WIDTH-1:0] pix_buf [0:N-1][0:N-1];

    assign start   = conv_done && !conv_done_q;
    assign at_last = (row_q == LAST_IDX) && (col_q == LAST_IDX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= TX_IDLE;
            conv_done_q <= 1'b0;
            row_q       <= '0;
            col_q       <= '0;
            overrun_q   <= 1'b0;
        end else begin
            conv_done_q <= conv_done;
            // A second frame request cannot be queued; flag it and drop it.
            if (start && state_q != TX_IDLE)
                overrun_q <= 1'b1;
            case (state_q)
                TX_IDLE: begin
                    if (start)
                        state_q <= TX_CAPTURE;
                end
                TX_CAPTURE: begin
                    row_q   <= '0;
                    col_q   <= '0;
                    state_q <= TX_SEND;
                end
                TX_SEND: begin
                    if (m_ready) begin
                        if (col_q == LAST_IDX) begin
                            col_q <= '0;
                            if (row_q == LAST_IDX) begin
                                row_q   <= '0;
                                state_q <= TX_DONE;
                            end else begin
                                row_q <= row_q + 1'b1;
                            end
                        end else begin
                            col_q <= col_q + 1'b1;
                        end
                    end
                end
                TX_DONE: begin
                    state_q <= TX_IDLE;
                end
                default: state_q <= TX_IDLE;
            endcase
        end
    end

    // Buffer content is don't-care under reset, so it carries no reset.
    always_ff @(posedge clk) begin
        if (state_q == TX_CAPTURE)
            pix_buf <= conv_ofmap;
    end

    assign m_valid = (state_q == TX_SEND);
    assign m_last  = m_valid && at_last;
    assign m_data  = m_valid ? pix_buf[row_q][col_q] : '0;
    assign busy    = (state_q == TX_CAPTURE) || (state_q == TX_SEND);
    assign tx_done = (state_q == TX_DONE);
    assign overrun = overrun_q;

endmodule

// File: tb/tb_conv_ofmap_tx.sv
// Scoreboard bench for conv_ofmap_tx: expected beats are queued when a frame is
// triggered and compared as the DUT hands them over.
module tb_conv_ofmap_tx;
    localparam int DW = 8;
    localparam int N  = 4;

    logic          clk;
    logic          reset;
    logic          conv_done;
    logic [DW-1:0] ofmap [0:N-1][0:N-1];
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          m_last;
    logic          busy;
    logic          tx_done;
    logic          overrun;

    int checks = 0;
    int errors = 0;
    logic [DW:0] exp_q [$];

    conv_ofmap_tx dut (
        .clk        (clk),
        .reset      (reset),
        .conv_done  (conv_done),
        .conv_ofmap (ofmap),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .busy       (busy),
        .tx_done    (tx_done),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_ofmap(input bit all_ff);
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                ofmap[r][c] = all_ff ? 8'hFF : DW'(r * 16 + c);
    endtask

    task automatic push_frame();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                exp_q.push_back({(r == N - 1) && (c == N - 1), DW'(r * 16 + c)});
    endtask

    // Raise conv_done and walk through the two-cycle start latency.
    task automatic start_frame();
        conv_done = 1'b1;
        push_frame();
        cyc();
        check_eq("lat_capture_valid", {31'd0, m_valid}, 32'd0);
        check_eq("lat_capture_busy", {31'd0, busy}, 32'd1);
        cyc();
        check_eq("lat_first_valid", {31'd0, m_valid}, 32'd1);
    endtask

    // mode 0: ready always; mode 1: ready 1,0,0,1; mode 2: ready always + conv_done glitch
    task automatic stream(input int mode, input int max_beats);
        int          beats = 0;
        bit          stalled = 1'b0;
        logic [DW-1:0] prev_data = '0;
        logic        prev_last = 1'b0;
        logic [DW:0] e;
        int          k;
        for (k = 0; k < 400 && beats < max_beats; k++) begin
            if (mode == 1) m_ready = (k % 4 == 0) || (k % 4 == 3);
            else           m_ready = 1'b1;
            if (mode == 2 && k == 5) conv_done = 1'b0;
            if (mode == 2 && k == 7) conv_done = 1'b1;
            check_eq("send_valid", {31'd0, m_valid}, 32'd1);
            if (stalled) begin
                check_eq("stall_data", {24'd0, m_data}, {24'd0, prev_data});
                check_eq("stall_last", {31'd0, m_last}, {31'd0, prev_last});
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("queue_empty", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("beat_data", {24'd0, m_data}, {24'd0, e[DW-1:0]});
                    check_eq("beat_last", {31'd0, m_last}, {31'd0, e[DW]});
                end
                beats++;
            end
            stalled   = m_valid && !m_ready;
            prev_data = m_data;
            prev_last = m_last;
            cyc();
        end
        check_eq("beat_count", beats, max_beats);
    endtask

    task automatic expect_done();
        check_eq("done_pulse", {31'd0, tx_done}, 32'd1);
        check_eq("done_valid", {31'd0, m_valid}, 32'd0);
        check_eq("done_queue", exp_q.size(), 32'd0);
        cyc();
        check_eq("done_clear", {31'd0, tx_done}, 32'd0);
        check_eq("idle_busy", {31'd0, busy}, 32'd0);
    endtask

    task automatic rearm();
        conv_done = 1'b0;
        m_ready   = 1'b0;
        repeat (3) cyc();
    endtask

    initial begin
        int nvalid;
        int ndone;
        reset     = 1'b1;
        conv_done = 1'b0;
        m_ready   = 1'b0;
        fill_ofmap(1'b0);
        repeat (3) cyc();
        check_eq("rst_valid", {31'd0, m_valid}, 32'd0);
        check_eq("rst_data", {24'd0, m_data}, 32'd0);
        check_eq("rst_last", {31'd0, m_last}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_done", {31'd0, tx_done}, 32'd0);
        check_eq("rst_overrun", {31'd0, overrun}, 32'd0);
        reset = 1'b0;
        cyc();
        check_eq("idle_valid", {31'd0, m_valid}, 32'd0);

        // Full-rate frame.
        m_ready = 1'b1;
        start_frame();
        stream(0, N * N);
        expect_done();
        check_eq("no_overrun_1", {31'd0, overrun}, 32'd0);
        rearm();

        // Back-pressured frame.
        start_frame();
        stream(1, N * N);
        expect_done();
        rearm();

        // Upstream overwrites its map after capture; conv_done then held 50 cycles.
        m_ready = 1'b1;
        start_frame();
        fill_ofmap(1'b1);
        stream(0, N * N);
        expect_done();
        nvalid = 0;
        ndone  = 0;
        for (int i = 0; i < 50; i++) begin
            m_ready = 1'b1;
            if (m_valid) nvalid++;
            if (tx_done) ndone++;
            cyc();
        end
        check_eq("held_no_valid", nvalid, 0);
        check_eq("held_no_done", ndone, 0);
        check_eq("no_overrun_2", {31'd0, overrun}, 32'd0);
        fill_ofmap(1'b0);
        rearm();

        // Re-trigger during send is dropped and flagged.
        m_ready = 1'b1;
        start_frame();
        stream(2, N * N);
        expect_done();
        nvalid = 0;
        for (int i = 0; i < 10; i++) begin
            if (m_valid) nvalid++;
            cyc();
        end
        check_eq("overrun_no_frame", nvalid, 0);
        check_eq("overrun_set", {31'd0, overrun}, 32'd1);
        rearm();
        check_eq("overrun_sticky", {31'd0, overrun}, 32'd1);

        // Reset mid-frame, conv_done held through release.
        m_ready = 1'b1;
        start_frame();
        stream(0, 3);
        reset = 1'b1;
        #1;
        check_eq("abort_valid", {31'd0, m_valid}, 32'd0);
        check_eq("abort_overrun", {31'd0, overrun}, 32'd0);
        check_eq("abort_busy", {31'd0, busy}, 32'd0);
        exp_q.delete();
        repeat (2) cyc();
        check_eq("abort_hold_valid", {31'd0, m_valid}, 32'd0);
        reset = 1'b0;
        push_frame();
        cyc();
        check_eq("relstart_capture", {31'd0, busy && !m_valid}, 32'd1);
        cyc();
        check_eq("relstart_valid", {31'd0, m_valid}, 32'd1);
        check_eq("relstart_pix0", {24'd0, m_data}, 32'd0);
        stream(0, N * N);
        expect_done();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
